uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide UART transmitter that drives the serial TX line using the same 8N1 framing and baud timing as the design's UART receiver. A small FIFO sits in front of the shift register, so the host logic can queue several bytes without waiting for each frame to finish. Queued frames go out back-to-back with no idle gap. It is the transmit half of the design's serial link.

## Interface
- BAUD, 2604 (12'hA2C), clocks per serial bit; 12-bit counter; legal 2..4095
- FIFO_DEPTH, 4, queued-byte capacity; power of two, 2..16
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- trmt  input  1  push request; tx_data is captured when trmt=1 and full=0
- tx_data  input  8  byte to queue
- TX  output  1  serial line; idles high
- tx_done  output  1  sticky; high once the last queued frame's stop bit completes
- full  output  1  FIFO count == FIFO_DEPTH
- busy  output  1  frame in flight or FIFO non-empty

## Operation
- Outputs at reset: TX=1, tx_done=0, full=0, busy=0.
- Reset clears the FIFO, bit counter, baud counter and state. It acts asynchronously mid-frame, and TX returns to 1 immediately.
- FIFO:
  - Circular buffer with read pointer, write pointer and count. Count width is $clog2(FIFO_DEPTH+1).
  - A push is accepted only if full=0 in that cycle.
  - A push while full is dropped silently, even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves count unchanged.
- State machine, two states, IDLE and TRANS:
  - IDLE, FIFO non-empty: pop the head and load the shift register with {1 (stop), data[7:0], 0 (start)}. Clear baud_cnt and bit_cnt, clear tx_done, then go to TRANS.
  - IDLE, FIFO empty: stay in IDLE, TX=1.
  - TRANS: TX equals shift register bit 0. baud_cnt counts 0..BAUD-1.
  - TRANS, at baud_cnt==BAUD-1: shift right, fill with 1, bit_cnt+1, baud_cnt returns to 0.
  - TRANS, when bit_cnt reaches 10 (all bits shifted) and the FIFO is non-empty: pop and reload in that same cycle, stay in TRANS. There is no idle clock between frames.
  - TRANS, when bit_cnt reaches 10 and the FIFO is empty: set tx_done and go to IDLE.
- Data is sent LSB first.
- tx_done stays high until the next frame load.
- busy = (state==TRANS) | (count!=0).

## Timing
- Let trmt be sampled high at edge E0 with the FIFO empty and state IDLE.
  - The entry is written at E0.
  - The frame loads at E1, and TX goes low after E1.
- Every bit, stop bit included, is held exactly BAUD clocks.
- One frame is 10*BAUD clocks, 11*BAUD with parity.
- tx_done rises on the edge that ends the stop bit: E1 + 10*BAUD.
- full and busy are updated on the same edge as the push or pop that changes them.
- Consecutive frames: the stop bit of frame n is followed directly by the start bit of frame n+1.

## Configuration
- UART_TX_PARITY_EN defined: an even-parity bit (XOR of data[7:0]) is inserted between data[7] and stop.
  - The shift register is 11 bits and the terminal bit_cnt is 11.
  - The frame is 11*BAUD clocks.
- UART_TX_PARITY_EN undefined: 8N1 framing, 10-bit frames as described above.

## Test plan
- Single byte, BAUD=16, tx_data=8'hA5:
  - TX low after E1, then bits 0,1,0,1,0,0,1,0,1,1, each 16 clocks.
  - tx_done=1 at E1+160; busy=0 from then on.
- Back-to-back, push 8'h00 then 8'hFF on consecutive cycles:
  - The two frames are contiguous; the first stop bit is followed immediately by a start bit (TX low).
  - tx_done rises only after the second frame.
- Overflow, DEPTH=4, trmt held high for 6 cycles with distinct bytes:
  - 5 bytes are accepted (one loaded, four queued); full=1 from the 5th push.
  - The 6th byte never appears on TX.
- Reset mid-frame, rst_n low during data bit 3 with 2 bytes queued:
  - TX=1, busy=0, full=0 immediately.
  - No further frames are sent after reset releases.
- Parity build (UART_TX_PARITY_EN), tx_data=8'h07:
  - Parity bit 1, stop bit 1.
  - tx_done at E1+11*BAUD.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a small FIFO and back-to-back frames
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int BAUD       = 2604,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       full,
    output logic       busy
);

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [11:0]      BAUD_LAST = 12'(BAUD - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE,
        TRANS
    } state_t;

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [11:0]             baud_cnt_q, baud_cnt_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    tx_done_q, tx_done_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [7:0]              mem_q [FIFO_DEPTH];

    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic [7:0]              head;
    logic [FRAME_BITS-1:0]   frame;

    assign full       = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign push       = trmt & ~full;
    assign head       = mem_q[rd_ptr_q];

`ifdef UART_TX_PARITY_EN
    assign frame = {1'b1, ^head, head, 1'b0};
`else
    assign frame = {1'b1, head, 1'b0};
`endif

    // A frame ending with data still queued reloads on the same edge, so no idle clock appears.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_done_d  = tx_done_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            TRANS: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    shift_d    = {1'b1, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    baud_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            tx_done_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d    = frame;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_done_d  = 1'b0;
            state_d    = TRANS;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_done_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_done_q  <= tx_done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset; only entries behind the count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign TX      = (state_q == TRANS) ? shift_q[0] : 1'b1;
    assign tx_done = tx_done_q;
    assign busy    = (state_q == TRANS) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with BAUD=16, FIFO_DEPTH=4
module tb_uart_tx;

    localparam int B = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FN = 11;
`else
    localparam int FN = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX, tx_done, full, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int frames_seen = 0;
    logic [7:0] exp_q [$];

    uart_tx #(.BAUD(B), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
        .TX(TX), .tx_done(tx_done), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic drive(input logic [7:0] b, input bit accept);
        @(negedge clk);
        trmt = 1'b1;
        tx_data = b;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic idle_in;
        @(negedge clk);
        trmt = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (tx_done && !busy) break;
        end
        check("drain", {31'd0, tx_done & ~busy}, 32'd1);
    endtask

    task automatic mon_wait(input int n, inout bit ab);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // Frame decoder: samples each bit in its middle and scores against the queue.
    initial begin
        bit ab;
        logic [10:0] fr;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && TX === 1'b0) begin
                ab = 1'b0;
                fr = '1;
                mon_wait(8, ab);
                fr[0] = TX;
                for (int b = 1; b < FN; b++) begin
                    mon_wait(B, ab);
                    fr[b] = TX;
                end
                if (!ab) begin
                    frames_seen++;
                    check("mon_start", {31'd0, fr[0]}, 32'd0);
                    check("mon_stop", {31'd0, fr[FN-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
                    check("mon_parity", {31'd0, fr[9]}, {31'd0, ^fr[8:1]});
`endif
                    check("mon_frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("mon_data", {24'd0, fr[8:1]}, {24'd0, e});
                    end
                end
            end
        end
    end

    initial begin
        logic [10:0] fr;
        int seen0;
        rst_n = 1'b0;
        trmt = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_TX", {31'd0, TX}, 32'd1);
        check("rst_tx_done", {31'd0, tx_done}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte with exact per-clock TX pattern
        fr = mk_frame(8'hA5);
        drive(8'hA5, 1'b1);
        @(posedge clk); #1;
        check("e0_busy", {31'd0, busy}, 32'd1);
        check("e0_TX", {31'd0, TX}, 32'd1);
        idle_in;
        @(posedge clk);
        for (int i = 0; i < FN * B; i++) begin
            @(negedge clk);
            check($sformatf("bit%0d_TX", i / B), {31'd0, TX}, {31'd0, fr[i / B]});
            if (i == FN * B - 1) check("pre_done", {31'd0, tx_done}, 32'd0);
        end
        @(posedge clk); #1;
        check("done_at_E1+frame", {31'd0, tx_done}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("busy_stays_low", {31'd0, busy}, 32'd0);

        // Back-to-back frames
        drive(8'h00, 1'b1);
        @(posedge clk);
        drive(8'hFF, 1'b1);
        @(posedge clk);
        idle_in;
        repeat (FN * B - 1) @(posedge clk);
        #1;
        check("b2b_stop1", {31'd0, TX}, 32'd1);
        check("b2b_done_mid0", {31'd0, tx_done}, 32'd0);
        @(posedge clk); #1;
        check("b2b_start2", {31'd0, TX}, 32'd0);
        check("b2b_done_mid1", {31'd0, tx_done}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        repeat (FN * B) @(posedge clk);
        #1;
        check("b2b_done", {31'd0, tx_done}, 32'd1);
        check("b2b_busy_end", {31'd0, busy}, 32'd0);

        // Overflow: six pushes, the sixth is dropped
        seen0 = frames_seen;
        for (int i = 0; i < 6; i++) begin
            drive(8'h30 + 8'(i), i < 5);
            @(posedge clk); #1;
            check($sformatf("ovf_full%0d", i), {31'd0, full}, {31'd0, i >= 4});
        end
        idle_in;
        wait_done(8 * FN * B);
        check("ovf_queue_empty", exp_q.size(), 32'd0);
        check("ovf_frames", frames_seen - seen0, 32'd5);

        // Reset during data bit 3 with two bytes queued
        drive(8'h5A, 1'b1);
        @(posedge clk);
        drive(8'hC3, 1'b1);
        @(posedge clk);
        drive(8'h96, 1'b1);
        @(posedge clk);
        idle_in;
        repeat (70) @(posedge clk);
        #1;
        check("pre_rst_full", {31'd0, full}, 32'd0);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_TX", {31'd0, TX}, 32'd1);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_full", {31'd0, full}, 32'd0);
        seen0 = frames_seen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * FN * B) @(posedge clk);
        #1;
        check("post_rst_frames", frames_seen - seen0, 32'd0);
        check("post_rst_TX", {31'd0, TX}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_done", {31'd0, tx_done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
